// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one shift-and-correct
// step per clock, W steps per conversion, registered done/bin_out/err.

module bcd2bin_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // A shifted digit >= 8 carries a half-ten from the digit above; -3 restores it.
  assign d_o = (d_i >= 4'd8) ? d_i - 4'd3 : d_i;
endmodule

module bcd2bin #(
  parameter int D = 2,
  parameter int W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [4*D-1:0] bcd_in,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   bin_out,
  output logic           err
);
  localparam int CW = $clog2(W+1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q;
  logic [4*D-1:0]  bcd_q, bcd_sh, bcd_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q, err_q;
  logic [W-1:0]    bin_q;
  logic [D-1:0]    bad;

  assign {bcd_sh, acc_d} = {bcd_q, acc_q} >> 1;

  for (genvar g = 0; g < D; g++) begin : g_dig
    bcd2bin_digit u_dig (
      .d_i (bcd_sh[4*g +: 4]),
      .d_o (bcd_d[4*g +: 4])
    );
    assign bad[g] = bcd_in[4*g +: 4] > 4'd9;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (|bad) begin
              bin_q  <= '0;
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              bcd_q   <= bcd_in;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) begin
            bin_q   <= acc_d;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;
endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: D=2/W=7 and D=3/W=10 instances, directed vectors.

module tb_bcd2bin;
  typedef struct {
    logic [9:0] bin;
    logic       err;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start2 = 1'b0, start3 = 1'b0;
  logic [7:0]  bcd2 = '0;
  logic [11:0] bcd3 = '0;
  logic        busy2, done2, err2, busy3, done3, err3;
  logic [6:0]  bin2;
  logic [9:0]  bin3;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q2[$];
  exp_t q3[$];

  bcd2bin #(.D(2), .W(7)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
  );

  bcd2bin #(.D(3), .W(10)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .bin_out(bin3), .err(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) check("d2 unexpected done", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("d2 bin_out", {25'd0, bin2}, {22'd0, e.bin});
        check("d2 err", {31'd0, err2}, {31'd0, e.err});
        check("d2 done cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done3) begin
      if (q3.size() == 0) check("d3 unexpected done", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        check("d3 bin_out", {22'd0, bin3}, {22'd0, e.bin});
        check("d3 err", {31'd0, err3}, {31'd0, e.err});
        check("d3 done cycle", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1; the next edge accepts, returns at posedge+1 of cycle A.
  task automatic issue2(input logic [7:0] b, input int v, input logic e, input bit track);
    exp_t x;
    x.bin = 10'(v); x.err = e; x.cyc = cyc + 1 + (e ? 0 : 7);
    if (track) q2.push_back(x);
    start2 = 1'b1; bcd2 = b;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic issue3(input logic [11:0] b, input int v);
    exp_t x;
    x.bin = 10'(v); x.err = 1'b0; x.cyc = cyc + 1 + 10;
    q3.push_back(x);
    start3 = 1'b1; bcd3 = b;
    @(posedge clk); #1;
    start3 = 1'b0;
  endtask

  task automatic wait_done2();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done2) seen = 1;
    end
    if (!seen) check("d2 done timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done3();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (done3) seen = 1;
    end
    if (!seen) check("d3 done timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1;
    check("reset busy", {31'd0, busy2}, 32'd0);
    check("reset done", {31'd0, done2}, 32'd0);
    check("reset bin_out", {25'd0, bin2}, 32'd0);
    check("reset err", {31'd0, err2}, 32'd0);
    #20 rst_n = 1'b1;
    idle(2);

    // 99: busy for exactly 7 cycles, then done.
    issue2(8'h99, 99, 1'b0, 1);
    for (int i = 0; i < 7; i++) begin
      check("99 busy high", {31'd0, busy2}, 32'd1);
      check("99 done low", {31'd0, done2}, 32'd0);
      @(posedge clk); #1;
    end
    check("99 busy low at done", {31'd0, busy2}, 32'd0);
    check("99 done high", {31'd0, done2}, 32'd1);

    // Back-to-back, each start issued in the previous done cycle.
    issue2(8'h00, 0, 1'b0, 1);
    wait_done2();
    issue2(8'h42, 42, 1'b0, 1);
    wait_done2();
    issue2(8'h10, 10, 1'b0, 1);
    wait_done2();
    idle(3);

    // Invalid digit: done+err next cycle, busy never rises.
    issue2(8'h3A, 0, 1'b1, 1);
    check("3A busy low", {31'd0, busy2}, 32'd0);
    check("3A done", {31'd0, done2}, 32'd1);
    idle(1);
    check("3A done single", {31'd0, done2}, 32'd0);
    check("3A busy still low", {31'd0, busy2}, 32'd0);
    issue2(8'h25, 25, 1'b0, 1);
    wait_done2();
    idle(2);

    // start while busy is ignored.
    issue2(8'h87, 87, 1'b0, 1);
    idle(2);
    issue2(8'h11, 11, 1'b0, 0);
    wait_done2();
    check("87 bin_out held", {25'd0, bin2}, 32'd87);
    idle(12);

    // Reset mid-conversion.
    issue2(8'h55, 55, 1'b0, 1);
    idle(3);
    q2.delete();
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy2}, 32'd0);
    check("rst done", {31'd0, done2}, 32'd0);
    check("rst bin_out", {25'd0, bin2}, 32'd0);
    check("rst err", {31'd0, err2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(15);
    check("post-rst busy", {31'd0, busy2}, 32'd0);
    check("post-rst bin_out", {25'd0, bin2}, 32'd0);

    // Three-digit instance.
    issue3(12'h999, 999);
    wait_done3();
    issue3(12'h256, 256);
    wait_done3();
    idle(2);

    // Full sweep of valid two-digit inputs, back-to-back.
    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++) begin
        issue2(8'(t*16 + o), t*10 + o, 1'b0, 1);
        wait_done2();
      end
    idle(5);

    check("d2 queue drained", q2.size(), 32'd0);
    check("d3 queue drained", q3.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
